// File: rtl/rv32_bus_pkg.sv
// Shared types and helpers for the picorv32 bus fabric: FSM states, error
// cause codes and the address-to-region decode.
package rv32_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } bus_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } err_cause_t;

  // Extracts the region field; widths of 32 or more keep the whole shifted word.
  function automatic logic [31:0] region_of(input logic [31:0] addr,
                                            input int unsigned sel_lsb = 28,
                                            input int unsigned sel_width = 4);
    logic [31:0] mask;
    mask = (sel_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sel_width) - 32'd1);
    return (addr >> sel_lsb) & mask;
  endfunction

endpackage

// File: rtl/rv32_bus_watchdog.sv
// Saturating stall timer for the bus fabric. Expires on the stalled cycle that
// would bring the count up to TIMEOUT_CYCLES.
module rv32_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && count != LIMIT)
      count <= count + 1'b1;
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/rv32_bus_fabric.sv
// Registered address decoder and response mux between picorv32 and its bus
// targets, with unmapped/timeout termination and sticky error capture.
module rv32_bus_fabric
  import rv32_bus_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter int          SEL_LSB        = 28,
  parameter int          SEL_WIDTH      = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rv32_valid,
  output logic                    rv32_ready,
  input  logic [31:0]             rv32_addr,
  output logic [31:0]             rv32_rdata,
  output logic [NUM_SLAVES-1:0]   slv_valid,
  input  logic [NUM_SLAVES-1:0]   slv_ready,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  output logic                    err_irq,
  input  logic                    err_clear,
  output logic [31:0]             err_addr,
  output logic [1:0]              err_cause
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  bus_state_t  state, state_next;
  logic [SW-1:0] sel;
  logic [31:0] addr_q;
  logic [31:0] region;
  logic        mapped;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        expired;
  logic        err_entry;
  logic        err_flag;
  logic [31:0] entry_addr;
  err_cause_t  entry_cause;
  err_cause_t  cause_q;

  assign region = region_of(rv32_addr, SEL_LSB, SEL_WIDTH);
  assign mapped = region < 32'(NUM_SLAVES);

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(sel) == i) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // The address is sampled every idle cycle so the decode is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel    <= '0;
      addr_q <= '0;
    end else if (state == IDLE) begin
      sel    <= region[SW-1:0];
      addr_q <= rv32_addr;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rv32_valid) state_next = mapped ? BUSY : ERR;
      BUSY: begin
        if (!rv32_valid || sel_ready)
          state_next = IDLE;
        else if (expired)
          state_next = ERR;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rv32_ready = 1'b0;
    rv32_rdata = '0;
    slv_valid  = '0;
    case (state)
      BUSY: begin
        for (int i = 0; i < NUM_SLAVES; i++)
          slv_valid[i] = rv32_valid && (int'(sel) == i);
        rv32_ready = sel_ready;
        rv32_rdata = sel_rdata;
      end
      ERR: begin
        rv32_ready = 1'b1;
        rv32_rdata = ERR_DATA;
      end
      default: ;
    endcase
  end

  rv32_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  ((state == IDLE) && (state_next == BUSY)),
    .enable ((state == BUSY) && !sel_ready),
    .expired(expired)
  );

  assign err_entry   = (state != ERR) && (state_next == ERR);
  assign entry_cause = (state == IDLE) ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;
  assign entry_addr  = (state == IDLE) ? rv32_addr : addr_q;

  // First error wins until cleared; a capture in the clearing cycle still lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
      cause_q  <= CAUSE_NONE;
    end else if (err_entry && (!err_flag || err_clear)) begin
      err_flag <= 1'b1;
      err_addr <= entry_addr;
      cause_q  <= entry_cause;
    end else if (err_clear) begin
      err_flag <= 1'b0;
      err_addr <= '0;
      cause_q  <= CAUSE_NONE;
    end
  end

  assign err_irq   = err_flag;
  assign err_cause = cause_q;

endmodule

// File: tb/tb_rv32_bus_fabric.sv
// Self-checking bench for rv32_bus_fabric: directed scenarios plus randomized
// transactions checked against a per-transaction behavioural model.
module tb_rv32_bus_fabric;

  localparam int          NS   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            rv32_valid = 1'b0;
  logic            rv32_ready;
  logic [31:0]     rv32_addr = '0;
  logic [31:0]     rv32_rdata;
  logic [NS-1:0]   slv_valid;
  logic [NS-1:0]   slv_ready = '0;
  logic [32*NS-1:0] slv_rdata = '0;
  logic            err_irq;
  logic            err_clear = 1'b0;
  logic [31:0]     err_addr;
  logic [1:0]      err_cause;

  int errors = 0;
  int checks = 0;

  logic        m_flag = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_cause = 2'b00;

  always #5 clk = ~clk;

  rv32_bus_fabric #(
    .NUM_SLAVES(NS),
    .SEL_LSB(28),
    .SEL_WIDTH(4),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERRD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rv32_valid(rv32_valid),
    .rv32_ready(rv32_ready),
    .rv32_addr(rv32_addr),
    .rv32_rdata(rv32_rdata),
    .slv_valid(slv_valid),
    .slv_ready(slv_ready),
    .slv_rdata(slv_rdata),
    .err_irq(err_irq),
    .err_clear(err_clear),
    .err_addr(err_addr),
    .err_cause(err_cause)
  );

  task automatic check_err_regs(input string tag);
    checks++;
    if (err_irq !== m_flag) begin
      errors++;
      $display("[TB] FAIL %s err_irq got=%b exp=%b", tag, err_irq, m_flag);
    end
    checks++;
    if (err_addr !== m_addr) begin
      errors++;
      $display("[TB] FAIL %s err_addr got=%h exp=%h", tag, err_addr, m_addr);
    end
    checks++;
    if (err_cause !== m_cause) begin
      errors++;
      $display("[TB] FAIL %s err_cause got=%b exp=%b", tag, err_cause, m_cause);
    end
  endtask

  // One CPU transaction; the slave answers wait_c cycles after it is selected
  // unless never is set. clr_with pulses err_clear alongside the first valid cycle.
  task automatic do_txn(input logic [31:0] addr, input int wait_c,
                        input bit never, input bit clr_with);
    int            region, n, exp_n, busy_n;
    bit            mapped, ok, got;
    logic [31:0]   exp_data, rd;
    logic [NS-1:0] exp_sv;

    region = int'(addr[31:28]);
    mapped = region < NS;
    for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = $urandom;
    ok = mapped && !never && (wait_c < TO);
    if (!mapped) begin
      exp_n = 1; busy_n = 0;
    end else if (ok) begin
      exp_n = wait_c + 1; busy_n = exp_n;
    end else begin
      exp_n = TO + 1; busy_n = TO;
    end
    exp_data = ok ? slv_rdata[32*region +: 32] : ERRD;

    @(negedge clk);
    rv32_valid = 1'b1;
    rv32_addr  = addr;
    err_clear  = clr_with;
    slv_ready  = '0;
    n = 0; got = 0; rd = 'x;
    while (!got && n < TO + 4) begin
      @(negedge clk);
      err_clear = 1'b0;
      n++;
      slv_ready = '0;
      if (mapped && !never && n == wait_c + 1) slv_ready[region] = 1'b1;
      #1;
      exp_sv = '0;
      if (mapped && n <= busy_n) exp_sv[region] = 1'b1;
      checks++;
      if (slv_valid !== exp_sv) begin
        errors++;
        $display("[TB] FAIL slv_valid addr=%h cycle=%0d got=%b exp=%b", addr, n, slv_valid, exp_sv);
      end
      if (rv32_ready === 1'b1) begin
        got = 1;
        rd  = rv32_rdata;
      end
    end
    checks++;
    if (!got || n != exp_n) begin
      errors++;
      $display("[TB] FAIL latency addr=%h got=%0d (ready=%0d) exp=%0d", addr, n, got, exp_n);
    end
    checks++;
    if (rd !== exp_data) begin
      errors++;
      $display("[TB] FAIL rdata addr=%h got=%h exp=%h", addr, rd, exp_data);
    end

    if (clr_with) begin
      m_flag = 1'b0; m_addr = '0; m_cause = 2'b00;
    end
    if (!ok && !m_flag) begin
      m_flag = 1'b1; m_addr = addr; m_cause = mapped ? 2'b10 : 2'b01;
    end
    check_err_regs("txn");

    @(negedge clk);
    #1;
    checks++;
    if (slv_valid !== '0 || rv32_ready !== 1'b0 || rv32_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after addr=%h got sv=%b rdy=%b rd=%h exp 0/0/0",
               addr, slv_valid, rv32_ready, rv32_rdata);
    end
    rv32_valid = 1'b0;
    slv_ready  = '0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (rv32_ready !== 1'b0 || rv32_rdata !== '0 || slv_valid !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rdy=%b rd=%h sv=%b exp 0/0/0", rv32_ready, rv32_rdata, slv_valid);
    end
    check_err_regs("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mapped_read;
    do_txn(32'h1000_0004, 0, 0, 0);
    do_txn(32'h0000_0100, 3, 0, 0);
    do_txn(32'h3FFF_FFFC, 1, 0, 0);
  endtask

  task automatic test_unmapped;
    do_txn(32'h5000_0000, 0, 0, 0);
    do_txn(32'h6000_0010, 0, 0, 0);
  endtask

  task automatic test_clear_coincide;
    do_txn(32'h7000_0020, 0, 0, 1);
  endtask

  task automatic test_err_clear;
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_flag = 1'b0; m_addr = '0; m_cause = 2'b00;
    #1;
    check_err_regs("clear");
  endtask

  task automatic test_timeout;
    do_txn(32'h2000_0000, 0, 1, 0);
    do_txn(32'h2000_0040, TO - 1, 0, 0);
    do_txn(32'h3000_0000, TO, 0, 0);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    rv32_valid = 1'b1;
    rv32_addr  = 32'h2000_0008;
    slv_ready  = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (slv_valid !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL pre_reset_busy got=%b exp=%b", slv_valid, 4'b0100);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (slv_valid !== '0 || rv32_ready !== 1'b0 || rv32_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got sv=%b rdy=%b rd=%h exp 0/0/0", slv_valid, rv32_ready, rv32_rdata);
    end
    m_flag = 1'b0; m_addr = '0; m_cause = 2'b00;
    check_err_regs("mid_reset");
    rv32_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(32'h1000_0004, 0, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int k = 0; k < 40; k++) begin
      a = {4'($urandom_range(0, 7)), 28'($urandom)};
      do_txn(a, int'($urandom_range(0, 10)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0));
    end
  endtask

  task automatic test_back_to_back;
    do_txn(32'h0000_0000, 0, 0, 0);
    do_txn(32'h1000_0000, 0, 0, 0);
    do_txn(32'h2000_0000, 0, 0, 0);
    do_txn(32'h3000_0000, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_clear_coincide();
    test_err_clear();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
